// File: rtl/dh_key_exchange.sv
// Diffie-Hellman key agreement: constant-time square-and-multiply exponentiation
// built on a bit-serial interleaved shift-add modular multiplier.
module dh_key_exchange #(
    parameter int             W     = 64,
    parameter int             EXP_W = 16,
    parameter int             KEY_W = 128,
    parameter logic [W-1:0]   P     = W'(64'hFFFFFFFFFFFFFFC5),
    parameter logic [W-1:0]   G     = W'(37)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_change,
    input  logic [EXP_W-1:0] secret_key,
    input  logic [W-1:0]     partner_key,
    input  logic             val_p,
    output logic [W-1:0]     my_key,
    output logic             val_my_key,
    output logic [KEY_W-1:0] K,
    output logic             val_K,
    output logic             busy,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int JW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [W:0] PX = {1'b0, P};

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PUB_CALC     = 3'd1,
        WAIT_PARTNER = 3'd2,
        SEC_CALC     = 3'd3,
        DONE         = 3'd4
    } state_t;

    // Handshake: val_p is a single-cycle strobe qualifying partner_key; it is
    // consumed only in WAIT_PARTNER and only when key_change is low that cycle.
    state_t state_q, state_d;

    logic [EXP_W-1:0] exp_q;
    logic [W-1:0]     base_q, res_q, r_q, r_nx, mm_b;
    logic [IW-1:0]    idx_q;
    logic [JW-1:0]    j_q;
    logic             sq_q, mm_load_q, fin_q, err_pend_q;
    logic             calc, partner_ok, accept, reject;
    logic [W:0]       dbl, dbl_red, add;

    assign dbg_state  = state_q;
    assign calc       = (state_q == PUB_CALC) || (state_q == SEC_CALC);
    assign partner_ok = (partner_key >= W'(2)) && (partner_key < P);
    assign accept     = (state_q == WAIT_PARTNER) && val_p && !key_change && partner_ok;
    assign reject     = (state_q == WAIT_PARTNER) && val_p && !key_change && !partner_ok;

    // One iteration of the multiplier: r <- 2r mod P, then optionally + a mod P.
    always_comb begin
        mm_b    = sq_q ? res_q : base_q;
        dbl     = {r_q, 1'b0};
        dbl_red = (dbl >= PX) ? dbl - PX : dbl;
        add     = dbl_red + {1'b0, res_q};
        r_nx    = dbl_red[W-1:0];
        if (mm_b[idx_q]) begin
            r_nx = (add >= PX) ? W'(add - PX) : add[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        if (key_change) begin
            state_d = PUB_CALC;
        end else begin
            case (state_q)
                PUB_CALC:     if (fin_q)  state_d = WAIT_PARTNER;
                WAIT_PARTNER: if (accept) state_d = SEC_CALC;
                SEC_CALC:     if (fin_q)  state_d = DONE;
                default:      state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q      <= '0;
            base_q     <= '0;
            res_q      <= '0;
            r_q        <= '0;
            idx_q      <= '0;
            j_q        <= '0;
            sq_q       <= 1'b0;
            mm_load_q  <= 1'b0;
            fin_q      <= 1'b0;
            err_pend_q <= 1'b0;
            my_key     <= '0;
            K          <= '0;
            val_my_key <= 1'b0;
            val_K      <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            val_my_key <= 1'b0;
            val_K      <= 1'b0;
            err_pend_q <= reject;
            err        <= err_pend_q;
            if (key_change || accept) begin
                if (key_change) begin
                    exp_q  <= secret_key;
                    base_q <= G;
                    K      <= '0;
                end else begin
                    base_q <= partner_key;
                end
                res_q     <= W'(1);
                j_q       <= JW'(EXP_W - 1);
                sq_q      <= 1'b1;
                mm_load_q <= 1'b1;
                fin_q     <= 1'b0;
                busy      <= 1'b1;
            end else if (calc) begin
                if (fin_q) begin
                    fin_q <= 1'b0;
                    busy  <= 1'b0;
                    if (state_q == PUB_CALC) begin
                        my_key     <= res_q;
                        val_my_key <= 1'b1;
                    end else begin
                        K     <= KEY_W'(res_q);
                        val_K <= 1'b1;
                    end
                end else if (mm_load_q) begin
                    r_q       <= '0;
                    idx_q     <= IW'(W - 1);
                    mm_load_q <= 1'b0;
                end else begin
                    r_q   <= r_nx;
                    idx_q <= idx_q - 1'b1;
                    if (idx_q == '0) begin
                        // Square done -> multiply by base; multiply done -> keep it only if the bit is set.
                        if (sq_q) begin
                            res_q     <= r_nx;
                            sq_q      <= 1'b0;
                            mm_load_q <= 1'b1;
                        end else begin
                            if (exp_q[j_q]) res_q <= r_nx;
                            sq_q <= 1'b1;
                            if (j_q == '0) begin
                                fin_q <= 1'b1;
                            end else begin
                                j_q       <= j_q - 1'b1;
                                mm_load_q <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dh_key_exchange.sv
// Self-checking bench for dh_key_exchange (W=8, EXP_W=4, P=23, G=5).
module tb_dh_key_exchange;

    localparam int W = 8;
    localparam int EXP_W = 4;
    localparam int KEY_W = 16;
    localparam int unsigned PM = 23;
    localparam int unsigned GM = 5;
    localparam int L = 73;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_change;
    logic [EXP_W-1:0] secret_key;
    logic [W-1:0]     partner_key;
    logic             val_p;
    logic [W-1:0]     my_key;
    logic             val_my_key;
    logic [KEY_W-1:0] K;
    logic             val_K;
    logic             busy;
    logic             err;
    logic [2:0]       dbg_state;

    dh_key_exchange #(.W(W), .EXP_W(EXP_W), .KEY_W(KEY_W), .P(8'd23), .G(8'd5)) dut (
        .clk(clk), .reset(reset), .key_change(key_change), .secret_key(secret_key),
        .partner_key(partner_key), .val_p(val_p), .my_key(my_key), .val_my_key(val_my_key),
        .K(K), .val_K(val_K), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    int unsigned cur_x;
    int unsigned last_k;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference: plain repeated multiplication mod P.
    function automatic int unsigned model_pow(input int unsigned b, input int unsigned e);
        int unsigned r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % PM;
        return r;
    endfunction

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input int unsigned x);
        key_change = 1'b1;
        secret_key = EXP_W'(x);
        cur_x = x;
        tick();
        key_change = 1'b0;
    endtask

    task automatic send_p(input int unsigned p);
        val_p = 1'b1;
        partner_key = W'(p);
        tick();
        val_p = 1'b0;
    endtask

    task automatic send_reject(input int unsigned p, input string tag);
        send_p(p);
        check_eq({tag, "_err_early"}, 32'(err), 0);
        tick();
        check_eq({tag, "_err"}, 32'(err), 1);
        tick();
        check_eq({tag, "_err_width"}, 32'(err), 0);
        check_eq({tag, "_no_valk"}, 32'(val_K), 0);
    endtask

    task automatic quiet(input int cycles, input string tag);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (val_my_key !== 1'b0 || val_K !== 1'b0 || err !== 1'b0) hits++;
        end
        check_eq({tag, "_quiet"}, 32'(hits), 0);
    endtask

    task automatic wait_result(input bit is_k, input string tag);
        int n = 0;
        int bad_busy = 0;
        logic [31:0] want;
        while (((is_k ? val_K : val_my_key) !== 1'b1) && n < 300) begin
            if (busy !== 1'b1) bad_busy++;
            if ((is_k ? val_my_key : val_K) !== 1'b0) bad_busy++;
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(L));
        check_eq({tag, "_busy_run"}, 32'(bad_busy), 0);
        check_eq({tag, "_busy_pulse"}, 32'(busy), 0);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check_eq(tag, is_k ? 32'(K) : 32'(my_key), want);
        if (is_k) last_k = want;
        tick();
        check_eq({tag, "_width"}, 32'(is_k ? val_K : val_my_key), 0);
        check_eq({tag, "_hold"}, is_k ? 32'(K) : 32'(my_key), want);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_my_key"}, 32'(my_key), 0);
        check_eq({tag, "_K"}, 32'(K), 0);
        check_eq({tag, "_flags"}, 32'({val_my_key, val_K, busy, err}), 0);
    endtask

    // Stimulus
    initial begin
        int unsigned x, pr;
        reset = 1'b1; key_change = 1'b0; val_p = 1'b0;
        secret_key = '0; partner_key = '0;
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Val_p in IDLE is ignored.
        send_p(19);
        quiet(4, "idle_valp");
        check_eq("idle_K", 32'(K), 0);

        // Basic exchange x=6, partner 19.
        start_key(6);
        exp_q.push_back(model_pow(GM, cur_x));
        wait_result(0, "t1_my");
        send_p(19);
        exp_q.push_back(model_pow(19, cur_x));
        wait_result(1, "t1_K");

        // Val_p in DONE is ignored, valid or not.
        send_p(7);
        quiet(3, "done_valp");
        send_p(23);
        quiet(3, "done_bad_valp");
        check_eq("done_K_held", 32'(K), last_k);

        // Zero exponent.
        start_key(0);
        exp_q.push_back(model_pow(GM, cur_x));
        wait_result(0, "t2_my");
        check_eq("t2_K_cleared", 32'(K), 0);
        send_p(19);
        exp_q.push_back(model_pow(19, cur_x));
        wait_result(1, "t2_K");

        // Rejected partner keys at both boundaries, then a good one.
        start_key(6);
        exp_q.push_back(model_pow(GM, cur_x));
        wait_result(0, "t3_my");
        send_reject(23, "rej_p");
        send_reject(1, "rej_1");
        send_reject(0, "rej_0");
        send_p(19);
        exp_q.push_back(model_pow(19, cur_x));
        wait_result(1, "t3_K");

        // Abort a public-key computation midway.
        start_key(6);
        quiet(29, "abort_first");
        start_key(15);
        exp_q.push_back(model_pow(GM, cur_x));
        wait_result(0, "t4_my");

        // Key_change and val_p together: key_change wins.
        key_change = 1'b1; secret_key = 4'd3; cur_x = 3;
        val_p = 1'b1; partner_key = 8'd19;
        tick();
        key_change = 1'b0; val_p = 1'b0;
        exp_q.push_back(model_pow(GM, cur_x));
        wait_result(0, "coll_my");
        check_eq("coll_K", 32'(K), 0);

        // Reset 40 cycles into SEC_CALC.
        send_p(19);
        quiet(39, "t5_run");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("t5_reset");
        quiet(100, "t5_after");
        start_key(6);
        exp_q.push_back(model_pow(GM, cur_x));
        wait_result(0, "t5_my");

        // Randomized exchanges.
        for (int it = 0; it < 5; it++) begin
            x = $urandom_range(0, 15);
            start_key(x);
            exp_q.push_back(model_pow(GM, cur_x));
            wait_result(0, "rnd_my");
            pr = $urandom_range(0, 30);
            if (pr < 2 || pr >= PM) begin
                send_reject(pr, "rnd_rej");
                pr = $urandom_range(2, PM - 1);
            end
            send_p(pr);
            exp_q.push_back(model_pow(pr, cur_x));
            wait_result(1, "rnd_K");
        end

        check_eq("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dh_key_exchange.md
# dh_key_exchange

Parametrised Diffie-Hellman key-agreement engine with true modular reduction at every step. It computes the public key G^x mod P from a loaded secret exponent x, accepts the partner's public key, and computes the shared secret partner^x mod P. The shared secret is zero-extended to the cipher key width and feeds the AES key-expansion input. Exponentiation runs in constant time: the cycle count does not depend on the secret.

## Interface
- W, 64: modulus/operand width in bits.
- EXP_W, 16: secret exponent width in bits.
- KEY_W, 128: width of K; must satisfy KEY_W ≥ W.
- P, 64'hFFFFFFFFFFFFFFC5: prime modulus. Must be odd and satisfy 3 ≤ P < 2^W.
- G, 37: generator. Must satisfy 2 ≤ G < P.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- key_change, in, 1: one-cycle pulse; loads secret_key and starts the public-key computation.
- secret_key, in, EXP_W: secret exponent x; sampled only when key_change is high.
- partner_key, in, W: partner public key; sampled when val_p is high.
- val_p, in, 1: partner_key valid strobe.
- my_key, out, W: public key G^x mod P.
- val_my_key, out, 1: one-cycle pulse when my_key becomes valid.
- K, out, KEY_W: shared secret, zero-extended.
- val_K, out, 1: one-cycle pulse when K becomes valid.
- busy, out, 1: high while an exponentiation is in progress.
- err, out, 1: one-cycle pulse when a partner key is rejected.

## Operation
- FSM states: IDLE, PUB_CALC, WAIT_PARTNER, SEC_CALC, DONE.
- **IDLE.** key_change → PUB_CALC with base = G and exp = secret_key.
- **PUB_CALC.** On completion: my_key ← result, pulse val_my_key, → WAIT_PARTNER.
- **WAIT_PARTNER.** val_p with 2 ≤ partner_key < P → SEC_CALC with base = partner_key.
  - val_p with partner_key < 2 or partner_key ≥ P → pulse err on the next cycle and remain in WAIT_PARTNER.
- **SEC_CALC.** On completion: K ← {0, result}, pulse val_K, → DONE.
- **DONE.** Holds my_key and K. Further val_p is ignored. key_change restarts.
- val_p is ignored in every state except WAIT_PARTNER.
- key_change in any state aborts any computation in progress, clears K to 0, loads the new secret, and → PUB_CALC. my_key keeps its old value until the new val_my_key.
- key_change and val_p in the same cycle: key_change wins and val_p is dropped.
- **Exponentiation** (left-to-right, constant time):
  - Start with res = 1.
  - For j = EXP_W-1 down to 0: res ← res·res mod P; t ← res·base mod P; if exp[j] then res ← t.
  - Both modmuls are always executed, so a zero exponent bit costs the same as a one bit.
  - Exponent 0 yields 1.
- **modmul(a, b)**, interleaved shift-add, operands < P:
  - Start with r = 0.
  - For i = W-1 down to 0: r ← 2r, then subtract P if r ≥ P; if b[i], r ← r + a, then subtract P if r ≥ P.
  - Intermediates are W+1 bits wide. The result is always < P.
- **Reset:** FSM → IDLE. my_key, K, val_my_key, val_K, busy and err all go to 0. Any computation in progress is aborted.

## Timing
- Each modmul takes W+1 cycles: 1 load cycle plus W iteration cycles.
- Exponentiation latency L = 2·EXP_W·(W+1) + 1 cycles.
- key_change sampled at edge n → val_my_key high in cycle n+L, and my_key valid from that cycle onward.
- Accepted val_p at edge m → val_K high in cycle m+L, and K valid from that cycle onward.
- busy is high from the cycle after the start edge through the cycle before the valid pulse, and low during the valid pulse.
- err is high in cycle m+1 for a rejected val_p at edge m.
- val_my_key, val_K and err are each exactly one cycle wide.
- A partner key can be accepted at the earliest in the cycle after val_my_key.

## Test plan
Bench parameters: W=8, EXP_W=4, P=23, G=5, KEY_W=16, giving L=73.
1. Reset, then key_change with secret_key=6 → val_my_key at +73 with my_key=8. Then val_p with partner_key=19 → val_K at +73 with K=16'h0002. busy low during both pulses.
2. secret_key=0 → my_key=1 after 73 cycles. Then partner_key=19 → K=1.
3. In WAIT_PARTNER, val_p with partner_key=23, then with 1 → err pulses one cycle after each, no val_K, state unchanged. Then partner_key=19 with x=6 → K=2.
4. key_change with x=6; 30 cycles later key_change with x=15 → no val_my_key from the first run; val_my_key 73 cycles after the second key_change with my_key=19.
5. reset asserted 40 cycles into SEC_CALC → all outputs 0 next cycle and no val_K. A fresh key_change with x=6 → my_key=8.
6. val_p pulses in IDLE and in DONE → ignored. No err, no val_K, K unchanged.
